// File: rtl/comparador_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | comparador_pkg: shared types, sizing helpers and default value set |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package comparador_pkg;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    BARRIDO   = 2'd1,
    RESULTADO = 2'd2
  } estado_t;

  localparam int c_num_defecto = 22;

  // Historical fixed combination set of the original 6-bit comparator.
  localparam logic [5:0] c_defecto [0:c_num_defecto-1] = '{
    6'd1,  6'd2,  6'd3,  6'd5,  6'd10, 6'd12, 6'd13, 6'd15,
    6'd20, 6'd21, 6'd22, 6'd23, 6'd25, 6'd30, 6'd31, 6'd32,
    6'd33, 6'd35, 6'd50, 6'd51, 6'd52, 6'd53
  };

  function automatic int calc_iw(input int profundidad);
    return (profundidad > 1) ? $clog2(profundidad) : 1;
  endfunction

  function automatic int calc_ng(input int profundidad, input int carriles);
    return (profundidad + carriles - 1) / carriles - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/comparador_grupo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | comparador_grupo: parallel lane compare with lowest-lane priority  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module comparador_grupo
  import comparador_pkg::*;
#(
  parameter int ANCHO    = 6,
  parameter int CARRILES = 4,
  localparam int LW      = calc_iw(CARRILES)
) (
  input  logic [ANCHO-1:0]                i_clave,
  input  logic [CARRILES-1:0][ANCHO-1:0]  i_dato,
  input  logic [CARRILES-1:0]             i_valido,
  output logic                            o_acierto,
  output logic [LW-1:0]                   o_carril
);

  logic [CARRILES-1:0] w_coincide;

  for (genvar l = 0; l < CARRILES; l++) begin : g_carril
    assign w_coincide[l] = i_valido[l] && (i_dato[l] == i_clave);
  end

  // Scanning from the top lane down leaves the lowest matching lane.
  always_comb begin
    o_carril = '0;
    for (int l = CARRILES - 1; l >= 0; l--) begin
      if (w_coincide[l]) o_carril = LW'(l);
    end
  end

  assign o_acierto = |w_coincide;

endmodule
`default_nettype wire

// File: rtl/comparador_conjunto_programable.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | comparador_conjunto_programable: writable set membership search    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module comparador_conjunto_programable
  import comparador_pkg::*;
#(
  parameter int ANCHO         = 6,
  parameter int PROFUNDIDAD   = 22,
  parameter int CARRILES      = 4,
  parameter int CARGA_INICIAL = 1,
  localparam int IW           = calc_iw(PROFUNDIDAD)
) (
  input  logic             Reloj,
  input  logic             Reset_n,
  input  logic             Escribir,
  input  logic [IW-1:0]    DirEscritura,
  input  logic [ANCHO-1:0] DatoEscritura,
  input  logic             ValidoEscritura,
  input  logic             Borrar,
  input  logic             ConsultaValida,
  output logic             ConsultaLista,
  input  logic [ANCHO-1:0] Entrada,
  output logic             ResultadoValido,
  input  logic             ResultadoListo,
  output logic             Salida,
  output logic [IW-1:0]    Indice,
  output logic             Ocupado
);

  localparam int NG = calc_ng(PROFUNDIDAD, CARRILES);
  localparam int GW = calc_iw(NG + 1);
  localparam int LW = calc_iw(CARRILES);

  localparam logic [1:0] c_reposo    = REPOSO;
  localparam logic [1:0] c_barrido   = BARRIDO;
  localparam logic [1:0] c_resultado = RESULTADO;

  localparam logic [GW-1:0] c_ultimo = GW'(NG);
  localparam bit c_carga = (CARGA_INICIAL == 1) && (ANCHO == 6) &&
                           (PROFUNDIDAD >= c_num_defecto);

  logic [ANCHO-1:0]                w_dato   [0:PROFUNDIDAD-1];
  logic                            w_valido [0:PROFUNDIDAD-1];
  logic [CARRILES-1:0][ANCHO-1:0]  w_grp_dato [0:NG];
  logic [CARRILES-1:0]             w_grp_val  [0:NG];
  logic [CARRILES-1:0][ANCHO-1:0]  w_lane_dato;
  logic [CARRILES-1:0]             w_lane_val;
  logic                            w_acierto;
  logic [LW-1:0]                   w_carril;
  logic [IW-1:0]                   w_indice;

  logic [1:0]       r_estado;
  logic [GW-1:0]    r_grupo;
  logic [ANCHO-1:0] r_clave;
  logic             r_salida;
  logic [IW-1:0]    r_indice;

  // Table storage; out-of-range addresses match no entry and are dropped.
  for (genvar e = 0; e < PROFUNDIDAD; e++) begin : g_entrada
    localparam bit c_ini_val = c_carga && (e < c_num_defecto);
    localparam logic [ANCHO-1:0] c_ini_dato =
      c_ini_val ? ANCHO'(c_defecto[e % c_num_defecto]) : '0;

    logic [ANCHO-1:0] r_dato;
    logic             r_valido;

    always_ff @(posedge Reloj or negedge Reset_n) begin
      if (!Reset_n) begin
        r_dato   <= c_ini_dato;
        r_valido <= c_ini_val;
      end else if (Borrar) begin
        r_valido <= 1'b0;
      end else if (Escribir && (DirEscritura == IW'(e))) begin
        r_dato   <= DatoEscritura;
        r_valido <= ValidoEscritura;
      end
    end

    assign w_dato[e]   = r_dato;
    assign w_valido[e] = r_valido;
  end

  // Lanes past the table end are padded as permanently invalid.
  for (genvar g = 0; g <= NG; g++) begin : g_grupo
    for (genvar l = 0; l < CARRILES; l++) begin : g_carril
      if (g * CARRILES + l < PROFUNDIDAD) begin : g_real
        assign w_grp_dato[g][l] = w_dato[g * CARRILES + l];
        assign w_grp_val[g][l]  = w_valido[g * CARRILES + l];
      end else begin : g_vacio
        assign w_grp_dato[g][l] = '0;
        assign w_grp_val[g][l]  = 1'b0;
      end
    end
  end

  assign w_lane_dato = w_grp_dato[r_grupo];
  assign w_lane_val  = w_grp_val[r_grupo];

  comparador_grupo #(
    .ANCHO    (ANCHO),
    .CARRILES (CARRILES)
  ) u_grupo (
    .i_clave   (r_clave),
    .i_dato    (w_lane_dato),
    .i_valido  (w_lane_val),
    .o_acierto (w_acierto),
    .o_carril  (w_carril)
  );

  assign w_indice = IW'(int'(r_grupo) * CARRILES + int'(w_carril));

  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) begin
      r_estado <= c_reposo;
      r_grupo  <= '0;
      r_clave  <= '0;
      r_salida <= 1'b0;
      r_indice <= '0;
    end else begin
      case (r_estado)
        c_reposo: begin
          if (ConsultaValida) begin
            r_clave  <= Entrada;
            r_grupo  <= '0;
            r_estado <= c_barrido;
          end
        end
        c_barrido: begin
          if (w_acierto) begin
            r_salida <= 1'b1;
            r_indice <= w_indice;
            r_estado <= c_resultado;
          end else if (r_grupo == c_ultimo) begin
            r_salida <= 1'b0;
            r_indice <= '0;
            r_estado <= c_resultado;
          end else begin
            r_grupo <= r_grupo + 1'b1;
          end
        end
        c_resultado: begin
          if (ResultadoListo) r_estado <= c_reposo;
        end
        default: r_estado <= c_reposo;
      endcase
    end
  end

  assign ConsultaLista   = (r_estado == c_reposo);
  assign ResultadoValido = (r_estado == c_resultado);
  assign Ocupado         = (r_estado != c_reposo);
  assign Salida          = r_salida;
  assign Indice          = r_indice;

endmodule
`default_nettype wire
